fetch_unit: RTL

- Parametrised successor to the single-cycle PC/instruction-fetch path: decouples fetch from decode for the pipelined core.
- Issues in-order, pipelined requests to a variable-latency instruction memory (valid/ready).
- Buffers returned words with their PC in a DEPTH-entry prefetch FIFO and hands them to decode over a valid/ready interface.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with a credit-limited prefetch FIFO and redirect flush
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req_vld,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_req_rdy,
  input  logic              i_imem_rsp_vld,
  input  logic [31:0]       i_imem_rsp_data,
  input  logic              i_redirect_vld,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_inst_vld,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_rdy,
  output logic              o_insn_vld,
  output logic [ADDR_W-1:0] o_pc_debug
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, outstanding, drop_cnt;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, target;
  logic [CW:0]       credit;
  logic              accept, rsp, push, pop;
  logic              unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  // Responses seen with nothing outstanding are leftovers from before a reset.
  always_comb begin
    credit         = {1'b0, outstanding} + {1'b0, count};
    target         = {i_redirect_pc[ADDR_W-1:2], 2'b00};
    o_imem_req_vld = i_reset && (credit < CREDITS) && !i_redirect_vld;
    o_imem_addr    = fetch_pc;
    accept         = o_imem_req_vld && i_imem_req_rdy;
    rsp            = i_imem_rsp_vld && (outstanding != '0);
    push           = rsp && (drop_cnt == '0) && !i_redirect_vld;
    o_inst_vld     = (count != '0) && !i_redirect_vld;
    pop            = o_inst_vld && i_inst_rdy;
    o_inst         = data_q[rd_ptr];
    o_inst_pc      = pc_q[rd_ptr];
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      data_q[wr_ptr] <= i_imem_rsp_data;
      pc_q[wr_ptr]   <= resp_pc;
    end
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      o_insn_vld  <= 1'b0;
      o_pc_debug  <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      o_insn_vld  <= pop;
      if (pop) o_pc_debug <= o_inst_pc;
      if (i_redirect_vld) begin
        fetch_pc <= target;
        resp_pc  <= target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
endmodule
